bus_cycle_sequencer: RTL and testbench
======================================

// Module: bus_cycle_sequencer
// PURPOSE
//  Parametrised bus interface unit that owns its own T-state sequencer (TI,T1,T2,TW,T3,T4).
//  Sits between the core load/store path and the external bus, in either multiplexed or separate address/data mode.
//  Adds wait states driven by a READY input, back-to-back cycles and a request/acknowledge handshake.
// PARAMETERS
//  AW        32  address width
//  DW        32  data width; MUXED=1 requires AW<=DW
//  MUXED      0  1: address driven on ad_out during T1, with ale; 0: separate address bus a_out
//  TO_CYCLES 16  wait-state timeout limit; used only when BIU_TIMEOUT_EN is defined
// PORTS
//  clk      in   1   clock; all state changes on posedge
//  rst_     in   1   asynchronous, active-low reset
//  req      in   1   core requests a bus cycle
//  dtr_     in   1   1=read, 0=write; sampled with req
//  addr     in   AW  transfer address
//  wdata    in   DW  write data
//  ack      out  1   one-cycle pulse in T4: the cycle is complete
//  rdata    out  DW  read data; valid while ack=1, then held
//  busy     out  1   1 in every state except TI
//  err      out  1   timeout flag; qualified by ack
//  t_state  out  3   TI=000, T1=001, T2=010, TW=011, T3=100, T4=101
//  a_out    out  AW  latched address when MUXED=0; 0 when MUXED=1
//  ad_out   out  DW  data/address output bus
//  ad_oe    out  1   output enable for ad_out
//  ad_in    in   DW  input data bus
//  ale      out  1   address latch enable; 1 only in T1 when MUXED=1
//  rd_      out  1   read strobe, active-low
//  wr_      out  1   write strobe, active-low
//  den_     out  1   data enable, active-low
//  ready    in   1   device ready; 0 inserts wait states
// BEHAVIOUR
//  Reset (asynchronous, takes effect immediately, including mid-cycle):
//   - state=TI; rd_=wr_=den_=1; ale=ad_oe=ack=err=0; rdata=0; address/data/direction latches=0.
//  Acceptance:
//   - req is sampled only in TI and in T4. On acceptance, addr, wdata and dtr_ are latched; next state is T1.
//   - Core must hold req low during the ack cycle unless it presents a new request.
//  Transitions:
//   - TI->T1 on req; otherwise stay in TI.
//   - T1->T2 always.
//   - T2->T3 if ready=1, else T2->TW.
//   - TW->T3 when ready=1.
//   - T3->T4 always.
//   - T4->T1 if req=1 (back-to-back, no TI gap), else T4->TI.
//  Strobes (registered from next-state; glitch-free):
//   - rd_=0 in T2, TW, T3 for reads.
//   - wr_=0 in T2, TW, T3 for writes.
//   - den_=0 in T2, TW, T3.
//   - rd_ and wr_ are never both 0.
//  Address/data buses:
//   - MUXED=1: ad_out=addr zero-extended and ad_oe=1 in T1.
//   - Writes: ad_out=wdata and ad_oe=1 in T2..T4.
//   - Reads: ad_oe=0 from T2 on.
//   - MUXED=0: a_out holds the latched address from T1 to T4.
//  Read data and latency:
//   - rdata captures ad_in on the T3->T4 edge.
//   - ack=1 only in T4.
//   - Latency: req seen in TI -> ack is 4 cycles + number of wait states.
//  Wait states: ready is sampled at the end of T2 and of each TW; there is no upper bound unless BIU_TIMEOUT_EN is defined.
// CONFIGURATION
//  BIU_TIMEOUT_EN defined:
//   - A counter of width $clog2(TO_CYCLES+1) is cleared on entry to TW and increments each TW cycle.
//   - When TO_CYCLES TW cycles have elapsed with ready=0: go to T4 with err=1 and ack=1; rdata is unchanged; strobes release.
//   - err clears on leaving T4.
//  BIU_TIMEOUT_EN undefined:
//   - No counter; TW persists until ready=1; err is tied to 0.
// TESTING
//  1. rst_ ->0 while in TW of a read -> same cycle: rd_=den_=1, t_state=000, busy=0, ack=0.
//  2. MUXED=0 read: addr=0x0000_1000, ready=1, ad_in=0xDEADBEEF -> t_state 001,010,100,101; rd_ low 2 cycles; ack in T4 with rdata=0xDEADBEEF.
//  3. Write: wdata=0x1234_5678, ready=0 for 2 cycles -> TW twice; wr_ low 4 cycles; ad_out=0x12345678 with ad_oe=1 in T2..T4; ack after 6 cycles.
//  4. MUXED=1 read at addr=0xA5A5_0004 -> T1: ad_out=0xA5A50004, ale=1, ad_oe=1; T2 onward: ale=0, ad_oe=0.
//  5. req held high with a new addr during T4 -> next state T1 (no TI); second transfer uses the new addr.
//  6. BIU_TIMEOUT_EN, TO_CYCLES=4, ready stuck 0 -> 4 TW cycles then T4 with ack=1, err=1; without the macro, t_state stays 011.

Source files
------------

// File: rtl/bus_cycle_sequencer_if.sv
// External bus of the T-state sequencer: split or multiplexed address/data, strobes and READY.
// master = bus interface unit, slave = memory/peripheral side.
interface bus_cycle_sequencer_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0] a_out;
    logic [DW-1:0] ad_out;
    logic          ad_oe;
    logic [DW-1:0] ad_in;
    logic          ale;
    logic          rd_;
    logic          wr_;
    logic          den_;
    logic          ready;

    modport master (
        output a_out, ad_out, ad_oe, ale, rd_, wr_, den_,
        input  ad_in, ready
    );

    modport slave (
        input  a_out, ad_out, ad_oe, ale, rd_, wr_, den_,
        output ad_in, ready
    );
endinterface

// File: rtl/bus_cycle_sequencer.sv
// Bus interface unit with its own TI/T1/T2/TW/T3/T4 sequencer; BIU_TIMEOUT_EN adds a wait-state timeout.
// Latency: req seen in TI -> ack in T4 after 4 cycles plus wait states; back-to-back cycles skip TI.
// Backpressure: ready=0 at the end of T2/TW stretches the cycle with TW states; busy is high until TI.
module bus_cycle_sequencer #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter bit MUXED     = 1'b0,
    parameter int TO_CYCLES = 16
) (
    input  logic          clk,
    input  logic          rst_,
    input  logic          req,
    input  logic          dtr_,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic          ack,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic          err,
    output logic [2:0]    t_state,
    bus_cycle_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        TI = 3'b000,
        T1 = 3'b001,
        T2 = 3'b010,
        TW = 3'b011,
        T3 = 3'b100,
        T4 = 3'b101
    } tstate_e;

    localparam int XW = (AW < DW) ? AW : DW;

    tstate_e       state;
    tstate_e       state_nxt;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          dtr_q;
    logic          accept;
    logic          timeout;
    logic          dir_rd;
    logic          win;
    logic          rd_nxt;
    logic          wr_nxt;
    logic          den_nxt;
    logic          ale_nxt;
    logic          oe_nxt;
    logic [DW-1:0] ad_nxt;
    logic [DW-1:0] addr_ext;

`ifdef BIU_TIMEOUT_EN
    localparam int CW = $clog2(TO_CYCLES + 1);
    logic [CW-1:0] to_cnt;

    assign timeout = (state == TW) && !bus.ready && (to_cnt == CW'(TO_CYCLES - 1));

    // TW is only ever entered from T2, so clearing in T2 is clearing on entry
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            to_cnt <= '0;
            err    <= 1'b0;
        end else begin
            if (state == T2)
                to_cnt <= '0;
            else if (state == TW)
                to_cnt <= to_cnt + 1'b1;
            err <= timeout;
        end
    end
`else
    logic unused_to_cycles;
    assign unused_to_cycles = (TO_CYCLES != 0);
    assign timeout          = 1'b0;
    assign err              = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_)
            state <= TI;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            TI: begin
                if (req) begin
                    state_nxt = T1;
                    accept    = 1'b1;
                end
            end
            T1: state_nxt = T2;
            T2: state_nxt = bus.ready ? T3 : TW;
            TW: begin
                if (bus.ready)
                    state_nxt = T3;
                else if (timeout)
                    state_nxt = T4;
            end
            T3: state_nxt = T4;
            T4: begin
                if (req) begin
                    state_nxt = T1;
                    accept    = 1'b1;
                end else begin
                    state_nxt = TI;
                end
            end
            default: state_nxt = TI;
        endcase
    end

    // Strobes and bus drive are decoded from the next state so they change on the same edge as t_state
    always_comb begin
        addr_ext          = '0;
        addr_ext[XW-1:0]  = addr[XW-1:0];
        dir_rd            = accept ? dtr_ : dtr_q;
        win               = (state_nxt == T2) || (state_nxt == TW) || (state_nxt == T3);
        rd_nxt            = !(win && dir_rd);
        wr_nxt            = !(win && !dir_rd);
        den_nxt           = !win;
        ale_nxt           = MUXED && (state_nxt == T1);
        oe_nxt            = 1'b0;
        ad_nxt            = '0;
        if (ale_nxt) begin
            oe_nxt = 1'b1;
            ad_nxt = addr_ext;
        end else if (!dir_rd && (win || state_nxt == T4)) begin
            oe_nxt = 1'b1;
            ad_nxt = wdata_q;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            dtr_q      <= 1'b0;
            rdata      <= '0;
            ack        <= 1'b0;
            bus.rd_    <= 1'b1;
            bus.wr_    <= 1'b1;
            bus.den_   <= 1'b1;
            bus.ale    <= 1'b0;
            bus.ad_oe  <= 1'b0;
            bus.ad_out <= '0;
        end else begin
            if (accept) begin
                addr_q  <= addr;
                wdata_q <= wdata;
                dtr_q   <= dtr_;
            end
            if (state == T3)
                rdata <= bus.ad_in;
            ack        <= (state_nxt == T4);
            bus.rd_    <= rd_nxt;
            bus.wr_    <= wr_nxt;
            bus.den_   <= den_nxt;
            bus.ale    <= ale_nxt;
            bus.ad_oe  <= oe_nxt;
            bus.ad_out <= ad_nxt;
        end
    end

    assign bus.a_out = MUXED ? '0 : addr_q;
    assign busy      = (state != TI);
    assign t_state   = state;
endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// Bench for bus_cycle_sequencer: split (dut0) and multiplexed (dut1) units share random stimulus,
// checked each cycle against a transaction-level state-trajectory model.
module tb_bus_cycle_sequencer;
    localparam logic [2:0] S_TI = 3'd0, S_T1 = 3'd1, S_T2 = 3'd2, S_TW = 3'd3, S_T3 = 3'd4, S_T4 = 3'd5;
    localparam int NT = 44;
    localparam int TO = 4;
`ifdef BIU_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef struct {
        int          idx;
        logic [2:0]  st;
        logic        busy, ack, err, rd_n, wr_n, den_n, oe0, oe1, ale1;
        logic [31:0] rdata, adv0, adv1, aout;
    } exp_t;

    logic        clk, rst_, req, dtr_, ready;
    logic [31:0] addr, wdata, ad_in;
    logic        ack0, busy0, err0, ack1, busy1, err1;
    logic [31:0] rdata0, rdata1;
    logic [2:0]  ts0, ts1;

    bus_cycle_sequencer_if #(.AW(32), .DW(32)) bus0 ();
    bus_cycle_sequencer_if #(.AW(32), .DW(32)) bus1 ();
    assign bus0.ad_in = ad_in;
    assign bus0.ready = ready;
    assign bus1.ad_in = ad_in;
    assign bus1.ready = ready;

    bus_cycle_sequencer #(.AW(32), .DW(32), .MUXED(1'b0), .TO_CYCLES(TO)) dut0 (
        .clk(clk), .rst_(rst_), .req(req), .dtr_(dtr_), .addr(addr), .wdata(wdata),
        .ack(ack0), .rdata(rdata0), .busy(busy0), .err(err0), .t_state(ts0), .bus(bus0)
    );
    bus_cycle_sequencer #(.AW(32), .DW(32), .MUXED(1'b1), .TO_CYCLES(TO)) dut1 (
        .clk(clk), .rst_(rst_), .req(req), .dtr_(dtr_), .addr(addr), .wdata(wdata),
        .ack(ack1), .rdata(rdata1), .busy(busy1), .err(err1), .t_state(ts1), .bus(bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        t_rd [NT];
    logic        t_to [NT];
    logic [31:0] t_addr [NT], t_wdata [NT], t_rdat [NT];
    int          t_wait [NT], t_gap [NT], t1idx [NT], t4idx [NT];
    logic [2:0]  sq [$];
    int          tq [$];
    exp_t        expq [$];
    int          lit0, lit1, lit2, lit3;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req_v);
        total++;
        if (act !== req_v) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req_v);
        end
    endtask

    // Expected outputs for a cycle spent in state st on behalf of transaction t
    function automatic exp_t mk(input int idx, input logic [2:0] st, input int t, input logic [31:0] rdv);
        exp_t e;
        logic w;
        w       = (st == S_T2) || (st == S_TW) || (st == S_T3);
        e.idx   = idx;
        e.st    = st;
        e.busy  = (st != S_TI);
        e.ack   = (st == S_T4);
        e.err   = (st == S_T4) && t_to[t];
        e.rd_n  = !(w && t_rd[t]);
        e.wr_n  = !(w && !t_rd[t]);
        e.den_n = !w;
        e.oe0   = !t_rd[t] && (w || st == S_T4);
        e.oe1   = (st == S_T1) || e.oe0;
        e.ale1  = (st == S_T1);
        e.adv0  = t_wdata[t];
        e.adv1  = (st == S_T1) ? t_addr[t] : t_wdata[t];
        e.aout  = t_addr[t];
        e.rdata = rdv;
        return e;
    endfunction

    // Compare process: one expected record per cycle, sampled 1 time unit after posedge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("m0.t_state", ts0, e.st);
                chk("m1.t_state", ts1, e.st);
                chk("m0.busy", busy0, e.busy);
                chk("m0.ack", ack0, e.ack);
                chk("m1.ack", ack1, e.ack);
                chk("m0.err", err0, e.err);
                chk("m1.err", err1, e.err);
                chk("m0.rdata", rdata0, e.rdata);
                chk("m1.rdata", rdata1, e.rdata);
                chk("m0.rd_", bus0.rd_, e.rd_n);
                chk("m0.wr_", bus0.wr_, e.wr_n);
                chk("m0.den_", bus0.den_, e.den_n);
                chk("m1.rd_", bus1.rd_, e.rd_n);
                chk("m1.wr_", bus1.wr_, e.wr_n);
                chk("m0.ale", bus0.ale, 1'b0);
                chk("m1.ale", bus1.ale, e.ale1);
                chk("m0.ad_oe", bus0.ad_oe, e.oe0);
                chk("m1.ad_oe", bus1.ad_oe, e.oe1);
                chk("m1.a_out", bus1.a_out, 32'h0);
                if (e.oe0) chk("m0.ad_out", bus0.ad_out, e.adv0);
                if (e.oe1) chk("m1.ad_out", bus1.ad_out, e.adv1);
                if (e.st != S_TI) chk("m0.a_out", bus0.a_out, e.aout);
                if (e.idx == lit0) begin
                    chk("lit.read_rdata", rdata0, 32'hDEADBEEF);
                    chk("lit.read_ack", ack0, 1'b1);
                end
                if (e.idx == lit1) chk("lit.write_ad_out", bus0.ad_out, 32'h12345678);
                if (e.idx == lit2) begin
                    chk("lit.mux_ad_out", bus1.ad_out, 32'hA5A50004);
                    chk("lit.mux_ale", bus1.ale, 1'b1);
                    chk("lit.b2b_a_out", bus0.a_out, 32'hA5A50004);
                end
                if (e.idx == lit2 + 1) chk("lit.mux_oe_off", bus1.ad_oe, 1'b0);
`ifdef BIU_TIMEOUT_EN
                if (e.idx == lit3) begin
                    chk("lit.timeout_ack", ack0, 1'b1);
                    chk("lit.timeout_err", err0, 1'b1);
                end
`else
                if (e.idx == lit3) chk("lit.stuck_tw", ts0, 3'b011);
`endif
            end
        end
    end

    initial begin
        logic [31:0] exp_rdata;
        logic [2:0]  cur, nx;
        int          tn, n;

        rst_ = 1'b0; req = 1'b0; dtr_ = 1'b0; ready = 1'b1; addr = '0; wdata = '0; ad_in = '0;
        lit0 = -1; lit1 = -1; lit2 = -1; lit3 = -1;

        // Transaction table: 4 directed cycles then random ones
        t_rd[0] = 1'b1; t_addr[0] = 32'h0000_1000; t_wdata[0] = 32'h0;         t_rdat[0] = 32'hDEADBEEF; t_wait[0] = 0; t_gap[0] = 0;
        t_rd[1] = 1'b0; t_addr[1] = 32'h0000_2000; t_wdata[1] = 32'h1234_5678; t_rdat[1] = 32'h1111_2222; t_wait[1] = 2; t_gap[1] = 0;
        t_rd[2] = 1'b1; t_addr[2] = 32'hA5A5_0004; t_wdata[2] = 32'h0;         t_rdat[2] = 32'h0BAD_F00D; t_wait[2] = 0; t_gap[2] = 0;
        t_rd[3] = 1'b1; t_addr[3] = 32'h0000_4000; t_wdata[3] = 32'h0;         t_rdat[3] = 32'h55AA_55AA; t_wait[3] = 6; t_gap[3] = 2;
        for (int i = 4; i < NT; i++) begin
            t_rd[i]    = 1'($urandom_range(0, 1));
            t_addr[i]  = $urandom;
            t_wdata[i] = $urandom;
            t_rdat[i]  = $urandom;
            t_wait[i]  = ($urandom_range(0, 7) == 0) ? 5 : int'($urandom_range(0, 3));
            t_gap[i]   = int'($urandom_range(0, 2));
        end

        // State trajectory: TI* T1 T2 TW^n (T3 | timeout) T4 per transaction
        sq.push_back(S_TI); tq.push_back(0);
        for (int i = 0; i < NT; i++) begin
            t_to[i] = 1'b0;
            for (int g = 0; g < t_gap[i]; g++) begin sq.push_back(S_TI); tq.push_back(i); end
            sq.push_back(S_T1); tq.push_back(i); t1idx[i] = sq.size() - 1;
            sq.push_back(S_T2); tq.push_back(i);
            if (TO_EN && t_wait[i] >= TO) begin
                for (int w = 0; w < TO; w++) begin sq.push_back(S_TW); tq.push_back(i); end
                t_to[i] = 1'b1;
            end else begin
                for (int w = 0; w < t_wait[i]; w++) begin sq.push_back(S_TW); tq.push_back(i); end
                sq.push_back(S_T3); tq.push_back(i);
            end
            sq.push_back(S_T4); tq.push_back(i); t4idx[i] = sq.size() - 1;
        end
        for (int g = 0; g < 3; g++) begin sq.push_back(S_TI); tq.push_back(NT - 1); end

        // Pin the model to hand-derived latencies and strobe widths
        chk("pin.lat_read", t4idx[0] - t1idx[0] + 1, 4);
        chk("pin.lat_write_2ws", t4idx[1] - t1idx[1] + 1, 6);
        chk("pin.lat_b2b", t4idx[2] - t1idx[2] + 1, 4);
        chk("pin.b2b_no_ti", t1idx[1], t4idx[0] + 1);
        n = 0;
        for (int k = t1idx[1]; k <= t4idx[1]; k++)
            if (sq[k] == S_T2 || sq[k] == S_TW || sq[k] == S_T3) n++;
        chk("pin.wr_low_cycles", n, 4);
        lit0 = t4idx[0];
        lit1 = t1idx[1] + 1;
        lit2 = t1idx[2];
        lit3 = t1idx[3] + 6;

        @(posedge clk); #1;
        chk("rst.t_state", ts0, 3'b000);
        chk("rst.busy", busy0, 1'b0);
        chk("rst.rd_", bus0.rd_, 1'b1);
        chk("rst.wr_", bus0.wr_, 1'b1);
        chk("rst.den_", bus0.den_, 1'b1);
        chk("rst.ale", bus1.ale, 1'b0);
        chk("rst.ad_oe", bus1.ad_oe, 1'b0);
        chk("rst.ack", ack0, 1'b0);
        chk("rst.err", err0, 1'b0);
        chk("rst.rdata", rdata0, 32'h0);

        @(negedge clk);
        rst_ = 1'b1;
        exp_rdata = '0;
        for (int k = 0; k < sq.size() - 1; k++) begin
            if (k > 0) @(negedge clk);
            cur = sq[k];
            nx  = sq[k + 1];
            tn  = tq[k + 1];
            if (nx == S_T1) begin
                req = 1'b1; dtr_ = t_rd[tn]; addr = t_addr[tn]; wdata = t_wdata[tn];
            end else begin
                req   = (cur == S_TI || cur == S_T4) ? 1'b0 : 1'($urandom_range(0, 1));
                dtr_  = 1'($urandom_range(0, 1));
                addr  = $urandom;
                wdata = $urandom;
            end
            if (cur == S_T2 || cur == S_TW) ready = (nx == S_T3);
            else ready = 1'($urandom_range(0, 1));
            ad_in = (cur == S_T3) ? t_rdat[tq[k]] : $urandom;
            if (cur == S_T3) exp_rdata = ad_in;
            expq.push_back(mk(k + 1, nx, tn, exp_rdata));
        end
        @(negedge clk);
        req = 1'b0;

        // Asynchronous reset while a read sits in TW
        @(negedge clk); req = 1'b1; dtr_ = 1'b1; addr = 32'h0000_3000; ready = 1'b1;
        @(negedge clk); req = 1'b0;
        @(negedge clk); ready = 1'b0;
        @(negedge clk);
        chk("arst.pre_tw", ts0, 3'b011);
        chk("arst.pre_rd_", bus0.rd_, 1'b0);
        #2 rst_ = 1'b0;
        #1;
        chk("arst.rd_", bus0.rd_, 1'b1);
        chk("arst.den_", bus0.den_, 1'b1);
        chk("arst.t_state", ts0, 3'b000);
        chk("arst.busy", busy0, 1'b0);
        chk("arst.ack", ack0, 1'b0);
        chk("arst.m1_t_state", ts1, 3'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
